// File: rtl/rggen_rtl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rggen_rtl_pkg
// Description : Shared types and helpers for the register bus: access
//               direction, response status, bridge FSM states and the
//               byte-strobe to bit-mask expansion.
// Revision    : 1.0 - initial release
// ============================================================================
package rggen_rtl_pkg;

  // Widest bus the strobe expansion helper supports.
  localparam int RGGEN_MAX_STROBE_WIDTH = 32;
  localparam int RGGEN_MAX_DATA_WIDTH   = 8 * RGGEN_MAX_STROBE_WIDTH;

  typedef enum logic {
    RGGEN_READ  = 1'b0,
    RGGEN_WRITE = 1'b1
  } rggen_direction;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

  typedef enum logic [1:0] {
    RGGEN_BRIDGE_IDLE     = 2'd0,
    RGGEN_BRIDGE_BUSY     = 2'd1,
    RGGEN_BRIDGE_RESPONSE = 2'd2
  } rggen_bridge_state;

  // Strobe bit k covers mask bits [8k+7:8k]; callers truncate to their width.
  function automatic logic [RGGEN_MAX_DATA_WIDTH-1:0] rggen_expand_strobe(
    input logic [RGGEN_MAX_STROBE_WIDTH-1:0] strobe
  );
    logic [RGGEN_MAX_DATA_WIDTH-1:0] mask;
    for (int i = 0; i < RGGEN_MAX_STROBE_WIDTH; i++) begin
      mask[8*i+:8] = {8{strobe[i]}};
    end
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rggen_register_if.sv
`default_nettype none
// ============================================================================
// Module      : rggen_register_if
// Description : Request/response bus between the bus bridge (master) and a
//               single register responder (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface rggen_register_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 32
) ();
  import rggen_rtl_pkg::*;

  logic                     request;
  logic [ADDRESS_WIDTH-1:0] address;
  rggen_direction           direction;
  logic [BUS_WIDTH-1:0]     write_data;
  logic [BUS_WIDTH-1:0]     write_mask;
  logic                     select;
  logic                     ready;
  rggen_status              status;
  logic [BUS_WIDTH-1:0]     read_data;

  modport master (
    output request, address, direction, write_data, write_mask,
    input  select, ready, status, read_data
  );

  modport slave (
    input  request, address, direction, write_data, write_mask,
    output select, ready, status, read_data
  );
endinterface
`default_nettype wire

// File: rtl/rggen_register_response_mux.sv
`default_nettype none
// ============================================================================
// Module      : rggen_register_response_mux
// Description : Merges the responses of all registers into one: completion,
//               OR of selected read data and OR of selected error statuses.
//               A miss returns zero data and the ERROR_STATUS error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module rggen_register_response_mux
  import rggen_rtl_pkg::*;
#(
  parameter int REGISTERS    = 1,
  parameter int BUS_WIDTH    = 32,
  parameter bit ERROR_STATUS = 1'b0
) (
  input  logic [REGISTERS-1:0] i_select,
  input  logic [REGISTERS-1:0] i_ready,
  input  rggen_status          i_status    [REGISTERS],
  input  logic [BUS_WIDTH-1:0] i_read_data [REGISTERS],
  output logic                 o_done,
  output logic [BUS_WIDTH-1:0] o_read_data,
  output logic                 o_error
);

  logic w_hit_error;

  // OR together data and errors of every selected register; overlaps are legal.
  always_comb begin
    o_read_data = '0;
    w_hit_error = 1'b0;
    for (int i = 0; i < REGISTERS; i++) begin
      if (i_select[i]) begin
        o_read_data = o_read_data | i_read_data[i];
        if ((i_status[i] == RGGEN_SLAVE_ERROR) || (i_status[i] == RGGEN_DECODE_ERROR)) begin
          w_hit_error = 1'b1;
        end
      end
    end
  end

  // A cycle with no select at all is a miss and completes immediately.
  assign o_done  = (|i_ready) || !(|i_select);
  assign o_error = (|i_select) ? w_hit_error : ERROR_STATUS;

endmodule
`default_nettype wire

// File: rtl/rggen_apb_register_bridge.sv
`default_nettype none
// ============================================================================
// Module      : rggen_apb_register_bridge
// Description : APB slave that turns each APB transfer into one register
//               request broadcast to all registers and returns the merged
//               response as a single-cycle pready.
// Revision    : 1.0 - initial release
// ============================================================================
module rggen_apb_register_bridge
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 32,
  parameter int REGISTERS     = 1,
  parameter bit ERROR_STATUS  = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_psel,
  input  logic                     i_penable,
  input  logic [ADDRESS_WIDTH-1:0] i_paddr,
  input  logic                     i_pwrite,
  input  logic [BUS_WIDTH-1:0]     i_pwdata,
  input  logic [BUS_WIDTH/8-1:0]   i_pstrb,
  output logic                     o_pready,
  output logic [BUS_WIDTH-1:0]     o_prdata,
  output logic                     o_pslverr,
  rggen_register_if.master         register_if [REGISTERS]
);

  rggen_bridge_state        r_state;
  rggen_bridge_state        w_next_state;
  logic [ADDRESS_WIDTH-1:0] r_address;
  rggen_direction           r_direction;
  logic [BUS_WIDTH-1:0]     r_write_data;
  logic [BUS_WIDTH-1:0]     r_write_mask;
  logic [BUS_WIDTH-1:0]     r_prdata;
  logic                     r_pslverr;

  logic                     w_request;
  logic                     w_latch;
  logic [BUS_WIDTH-1:0]     w_mask;
  logic [REGISTERS-1:0]     w_select;
  logic [REGISTERS-1:0]     w_ready;
  rggen_status              w_status    [REGISTERS];
  logic [BUS_WIDTH-1:0]     w_read_data [REGISTERS];
  logic                     w_done;
  logic                     w_error;
  logic [BUS_WIDTH-1:0]     w_mux_data;

  // The transfer is captured in the setup phase, so penable carries no information.
  logic w_unused_penable;
  assign w_unused_penable = i_penable;

  assign w_request = (r_state == RGGEN_BRIDGE_BUSY);
  assign w_latch   = (r_state == RGGEN_BRIDGE_IDLE) && i_psel;
  assign w_mask    = BUS_WIDTH'(rggen_expand_strobe(RGGEN_MAX_STROBE_WIDTH'(i_pstrb)));

  // Broadcast the latched request and gather the per-register responses.
  for (genvar i = 0; i < REGISTERS; i++) begin : g_register_if
    assign register_if[i].request    = w_request;
    assign register_if[i].address    = r_address;
    assign register_if[i].direction  = r_direction;
    assign register_if[i].write_data = r_write_data;
    assign register_if[i].write_mask = r_write_mask;
    assign w_select[i]               = register_if[i].select;
    assign w_ready[i]                = register_if[i].ready;
    assign w_status[i]               = register_if[i].status;
    assign w_read_data[i]            = register_if[i].read_data;
  end

  rggen_register_response_mux #(
    .REGISTERS    (REGISTERS),
    .BUS_WIDTH    (BUS_WIDTH),
    .ERROR_STATUS (ERROR_STATUS)
  ) u_response_mux (
    .i_select    (w_select),
    .i_ready     (w_ready),
    .i_status    (w_status),
    .i_read_data (w_read_data),
    .o_done      (w_done),
    .o_read_data (w_mux_data),
    .o_error     (w_error)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RGGEN_BRIDGE_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state: IDLE -> BUSY on psel, BUSY -> RESPONSE on done, then back.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RGGEN_BRIDGE_IDLE:     if (i_psel) w_next_state = RGGEN_BRIDGE_BUSY;
      RGGEN_BRIDGE_BUSY:     if (w_done) w_next_state = RGGEN_BRIDGE_RESPONSE;
      RGGEN_BRIDGE_RESPONSE: w_next_state = RGGEN_BRIDGE_IDLE;
      default:               w_next_state = RGGEN_BRIDGE_IDLE;
    endcase
  end

  // Request payload is latched once in IDLE and held until the next transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_address    <= '0;
      r_direction  <= RGGEN_READ;
      r_write_data <= '0;
      r_write_mask <= '0;
    end else if (w_latch) begin
      r_address    <= i_paddr;
      r_direction  <= i_pwrite ? RGGEN_WRITE : RGGEN_READ;
      r_write_data <= i_pwdata;
      r_write_mask <= w_mask;
    end
  end

  // Response is loaded on completion and cleared otherwise, so it is nonzero only in RESPONSE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prdata  <= '0;
      r_pslverr <= 1'b0;
    end else if (w_request && w_done) begin
      r_prdata  <= (r_direction == RGGEN_WRITE) ? '0 : w_mux_data;
      r_pslverr <= w_error;
    end else begin
      r_prdata  <= '0;
      r_pslverr <= 1'b0;
    end
  end

  assign o_pready  = (r_state == RGGEN_BRIDGE_RESPONSE);
  assign o_prdata  = r_prdata;
  assign o_pslverr = r_pslverr;

endmodule
`default_nettype wire

// File: tb/tb_rggen_apb_register_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_rggen_apb_register_bridge
// Description : Directed, table-driven bench for the APB register bridge with
//               a three-register responder model (0x00, 0x04, 0x08) and a
//               second bridge instance that only ever sees misses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rggen_apb_register_bridge;
  import rggen_rtl_pkg::*;

  localparam int AW         = 16;
  localparam int BW         = 32;
  localparam int NREG       = 3;
  localparam int MAX_CYCLES = 40;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          psel    = 1'b0;
  logic          penable = 1'b0;
  logic          pwrite  = 1'b0;
  logic [AW-1:0] paddr   = '0;
  logic [BW-1:0] pwdata  = '0;
  logic [3:0]    pstrb   = '0;
  logic          pready;
  logic          pslverr;
  logic [BW-1:0] prdata;

  logic          miss_en = 1'b0;
  logic          miss_psel;
  logic          miss_pready;
  logic          miss_pslverr;
  logic [BW-1:0] miss_prdata;
  assign miss_psel = psel & miss_en;

  rggen_register_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) reg_if  [NREG] ();
  rggen_register_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) miss_if [1] ();

  rggen_apb_register_bridge #(
    .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .REGISTERS(NREG), .ERROR_STATUS(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_psel(psel), .i_penable(penable), .i_paddr(paddr),
    .i_pwrite(pwrite), .i_pwdata(pwdata), .i_pstrb(pstrb), .o_pready(pready),
    .o_prdata(prdata), .o_pslverr(pslverr), .register_if(reg_if)
  );

  rggen_apb_register_bridge #(
    .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .REGISTERS(1), .ERROR_STATUS(1'b0)
  ) dut_miss (
    .clk(clk), .rst_n(rst_n), .i_psel(miss_psel), .i_penable(penable), .i_paddr(paddr),
    .i_pwrite(pwrite), .i_pwdata(pwdata), .i_pstrb(pstrb), .o_pready(miss_pready),
    .o_prdata(miss_prdata), .o_pslverr(miss_pslverr), .register_if(miss_if)
  );

  // Miss-only responder: never selects.
  assign miss_if[0].select    = 1'b0;
  assign miss_if[0].ready     = 1'b0;
  assign miss_if[0].status    = RGGEN_OKAY;
  assign miss_if[0].read_data = '0;

  // ---------------- responder model ----------------
  logic [BW-1:0]  reg_value [NREG] = '{32'hDEADBEEF, 32'h00000000, 32'h0BADF00D};
  logic [NREG-1:0] err_en   = '0;
  logic            overlap  = 1'b0;
  int unsigned     ready_delay = 0;
  int unsigned     wait_cnt    = 0;
  logic [NREG-1:0] hit_v;
  logic [NREG-1:0] rdy_v;

  logic           mon_request;
  logic [AW-1:0]  mon_address;
  rggen_direction mon_dir;
  logic [BW-1:0]  mon_wdata;
  logic [BW-1:0]  mon_mask;
  assign mon_request = reg_if[0].request;
  assign mon_address = reg_if[0].address;
  assign mon_dir     = reg_if[0].direction;
  assign mon_wdata   = reg_if[0].write_data;
  assign mon_mask    = reg_if[0].write_mask;

  for (genvar i = 0; i < NREG; i++) begin : g_resp
    assign hit_v[i] = reg_if[i].request &&
                      ((reg_if[i].address == AW'(4 * i)) ||
                       (overlap && (i == 2) && (reg_if[i].address == '0)));
    assign rdy_v[i]              = hit_v[i] && (wait_cnt >= ready_delay);
    assign reg_if[i].select      = hit_v[i];
    assign reg_if[i].ready       = rdy_v[i];
    assign reg_if[i].status      = err_en[i] ? RGGEN_SLAVE_ERROR : RGGEN_OKAY;
    assign reg_if[i].read_data   = hit_v[i] ? reg_value[i] : '0;
  end

  always @(posedge clk) begin
    wait_cnt <= mon_request ? wait_cnt + 1 : 0;
    for (int i = 0; i < NREG; i++) begin
      if (hit_v[i] && rdy_v[i] && (mon_dir == RGGEN_WRITE)) begin
        reg_value[i] <= (reg_value[i] & ~mon_mask) | (mon_wdata & mon_mask);
      end
    end
  end

  // ---------------- pready monitors ----------------
  int cyc = 0;
  int pready_pulses = 0;
  int last_cyc = 0;
  int last_gap = 0;
  int miss_pulses = 0;
  logic          miss_err_cap = 1'b0;
  logic [BW-1:0] miss_rd_cap  = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pready) begin
      pready_pulses <= pready_pulses + 1;
      last_gap      <= cyc - last_cyc;
      last_cyc      <= cyc;
    end
    if (miss_pready) begin
      miss_pulses  <= miss_pulses + 1;
      miss_err_cap <= miss_pslverr;
      miss_rd_cap  <= miss_prdata;
    end
  end

  // ---------------- checking helpers ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic            wr;
    logic [AW-1:0]   addr;
    logic [BW-1:0]   wdata;
    logic [3:0]      strb;
    int unsigned     delay;
    logic [NREG-1:0] err;
    logic            ovl;
    logic [BW-1:0]   exp_mask;
    logic [BW-1:0]   exp_rdata;
    logic            exp_err;
  } vec_t;

  // Starts in the setup cycle (state IDLE), returns at +1 after the edge that leaves RESPONSE.
  task automatic run_xfer(input vec_t v, output logic [BW-1:0] rd, output logic err,
                          output int lat, output int req_cycles, output int bad);
    rggen_direction exp_dir;
    exp_dir = v.wr ? RGGEN_WRITE : RGGEN_READ;
    psel = 1'b1; penable = 1'b0; pwrite = v.wr; paddr = v.addr; pwdata = v.wdata; pstrb = v.strb;
    lat = 0; req_cycles = 0; bad = 0;
    do begin
      @(posedge clk); #1;
      penable = 1'b1;
      lat++;
      if (mon_request) begin
        req_cycles++;
        if ((mon_address !== v.addr) || (mon_dir !== exp_dir) ||
            (mon_wdata !== v.wdata) || (mon_mask !== v.exp_mask)) bad++;
      end
      if ((pready !== 1'b1) && ((prdata !== '0) || (pslverr !== 1'b0))) bad++;
    end while ((pready !== 1'b1) && (lat < MAX_CYCLES));
    rd  = prdata;
    err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  vec_t vecs [9];

  initial begin
    logic [BW-1:0] rd;
    logic          err;
    int            lat;
    int            req;
    int            bad;
    int            base;
    vec_t          v;

    //          wr    addr      wdata         strb  dly err     ovl   exp_mask      exp_rdata     exp_err
    vecs[0] = '{1'b1, 16'h0004, 32'hA5A51234, 4'b0011, 0, 3'b000, 1'b0, 32'h0000FFFF, 32'h00000000, 1'b0};
    vecs[1] = '{1'b0, 16'h0004, 32'h00000000, 4'b0000, 0, 3'b000, 1'b0, 32'h00000000, 32'h00001234, 1'b0};
    vecs[2] = '{1'b0, 16'h0040, 32'h00000000, 4'b0000, 0, 3'b000, 1'b0, 32'h00000000, 32'h00000000, 1'b1};
    vecs[3] = '{1'b0, 16'h0000, 32'h00000000, 4'b0000, 3, 3'b000, 1'b0, 32'h00000000, 32'hDEADBEEF, 1'b0};
    vecs[4] = '{1'b1, 16'h0008, 32'h12345678, 4'b1100, 1, 3'b000, 1'b0, 32'hFFFF0000, 32'h00000000, 1'b0};
    vecs[5] = '{1'b0, 16'h0008, 32'h00000000, 4'b0000, 0, 3'b000, 1'b0, 32'h00000000, 32'h1234F00D, 1'b0};
    vecs[6] = '{1'b1, 16'h0000, 32'h11223344, 4'b0101, 0, 3'b001, 1'b0, 32'h00FF00FF, 32'h00000000, 1'b1};
    vecs[7] = '{1'b0, 16'h0000, 32'h00000000, 4'b0000, 0, 3'b000, 1'b0, 32'h00000000, 32'hDE22BE44, 1'b0};
    vecs[8] = '{1'b0, 16'h0000, 32'h00000000, 4'b0000, 0, 3'b100, 1'b1, 32'h00000000, 32'hDE36FE4D, 1'b1};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_pready",     pready,          0);
    check("rst_prdata",     prdata,          0);
    check("rst_pslverr",    pslverr,         0);
    check("rst_request",    mon_request,     0);
    check("rst_address",    32'(mon_address), 0);
    check("rst_direction",  32'(mon_dir),    32'(RGGEN_READ));
    check("rst_write_data", mon_wdata,       0);
    check("rst_write_mask", mon_mask,        0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven transfers, one idle cycle between them.
    for (int k = 0; k < 9; k++) begin
      ready_delay = vecs[k].delay;
      err_en      = vecs[k].err;
      overlap     = vecs[k].ovl;
      run_xfer(vecs[k], rd, err, lat, req, bad);
      check($sformatf("v%0d_latency", k), 32'(lat), 32'(2 + vecs[k].delay));
      check($sformatf("v%0d_request_cycles", k), 32'(req), 32'(1 + vecs[k].delay));
      check($sformatf("v%0d_payload_and_idle_outputs", k), 32'(bad), 0);
      check($sformatf("v%0d_prdata", k), rd, vecs[k].exp_rdata);
      check($sformatf("v%0d_pslverr", k), err, vecs[k].exp_err);
      check($sformatf("v%0d_after_pready", k), pready, 0);
      check($sformatf("v%0d_after_prdata", k), prdata, 0);
      err_en  = '0;
      overlap = 1'b0;
      @(posedge clk); #1;
    end

    // Unmapped read seen by both ERROR_STATUS settings.
    ready_delay = 0;
    miss_en = 1'b1;
    v = vecs[2];
    base = miss_pulses;
    run_xfer(v, rd, err, lat, req, bad);
    miss_en = 1'b0;
    check("miss_es1_latency", 32'(lat), 2);
    check("miss_es1_pslverr", err, 1);
    check("miss_es1_prdata", rd, 0);
    check("miss_es0_pulses", 32'(miss_pulses - base), 1);
    check("miss_es0_pslverr", miss_err_cap, 0);
    check("miss_es0_prdata", miss_rd_cap, 0);
    @(posedge clk); #1;

    // Reset asserted while BUSY: request drops at once and no pready follows.
    ready_delay = 5;
    base = pready_pulses;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0000; pstrb = 4'b0000; pwdata = '0;
    @(posedge clk); #1;
    penable = 1'b1;
    check("abort_request_before", mon_request, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("abort_request_async", mon_request, 0);
    check("abort_pready", pready, 0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("abort_no_pready", 32'(pready_pulses - base), 0);
    ready_delay = 0;
    v = vecs[1];
    run_xfer(v, rd, err, lat, req, bad);
    check("post_abort_latency", 32'(lat), 2);
    check("post_abort_prdata", rd, 32'h00001234);
    @(posedge clk); #1;

    // Back-to-back reads to 0x00 and 0x08.
    base = pready_pulses;
    v = vecs[7];
    run_xfer(v, rd, err, lat, req, bad);
    check("b2b0_latency", 32'(lat), 2);
    check("b2b0_prdata", rd, 32'hDE22BE44);
    v = vecs[5];
    run_xfer(v, rd, err, lat, req, bad);
    check("b2b1_latency", 32'(lat), 2);
    check("b2b1_prdata", rd, 32'h1234F00D);
    @(negedge clk);
    check("b2b_pulses", 32'(pready_pulses - base), 2);
    check("b2b_spacing", 32'(last_gap), 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
